// File: rtl/seven_seg_pkg.sv
// Shared segment definitions for the multiplexed seven-segment scanner.
// Cathodes are active-low; bit order is ca[0]=a through ca[6]=g.
package seven_seg_pkg;

   typedef enum logic [2:0] {
      SEG_A = 3'd0,
      SEG_B = 3'd1,
      SEG_C = 3'd2,
      SEG_D = 3'd3,
      SEG_E = 3'd4,
      SEG_F = 3'd5,
      SEG_G = 3'd6
   } seg_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Hex glyphs 0..F with lowercase b and d, active-low {g,f,e,d,c,b,a}.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit hex value to active-low seven-segment cathode pattern.
module seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] ca
);

   assign ca = HEX_SEG[value];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed NUM_DIGITS-digit hex display driver with blanking, blinking,
// leading-zero suppression, 16-level PWM brightness and an anti-ghost gap.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_HZ       = 100_000_000,
   parameter int SCAN_HZ      = 1000,
   parameter int BLINK_FRAMES = 256
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic [NUM_DIGITS-1:0]     blink,
   input  logic                      lz_en,
   input  logic [3:0]                bright,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                ca,
   output logic                      dp,
   output logic                      frame_tick
);

   localparam int DIV   = CLK_HZ / (SCAN_HZ * 16);
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   if (DIV < 1) begin : g_bad_div
      $error("seven_seg_scanner: CLK_HZ/(SCAN_HZ*16) must be at least 1");
   end
   if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seven_seg_scanner: NUM_DIGITS must be in 2..8");
   end
   if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("seven_seg_scanner: BLINK_FRAMES must be at least 1");
   end

   // Current state
   logic [PRE_W-1:0]      pre_cnt;
   logic [3:0]            pwm_cnt;
   logic [IDX_W-1:0]      idx;
   logic [BLK_W-1:0]      blink_cnt;
   logic                  blink_phase;
   logic [3:0]            slot_val;
   logic                  slot_dp;
   logic                  slot_vis;

   // Next state
   logic                  tick;
   logic                  slot_end;
   logic                  wrap;
   logic [PRE_W-1:0]      pre_n;
   logic [3:0]            pwm_n;
   logic [IDX_W-1:0]      idx_n;
   logic [BLK_W-1:0]      blink_cnt_n;
   logic                  blink_phase_n;
   logic [3:0]            val_n;
   logic                  dp_bit_n;
   logic                  vis_n;
   logic                  lit_n;
   logic [6:0]            seg_n;
   logic [NUM_DIGITS-1:0] upper_zero;

   // upper_zero[i]: digits i..NUM_DIGITS-1 are all zero.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         upper_zero[i] = ((digits >> (4 * i)) == '0);
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path
      // leaves a combinational output unassigned and no latch is inferred.
      tick          = (pre_cnt == PRE_LAST);
      slot_end      = tick && (pwm_cnt == 4'hF);
      wrap          = slot_end && (idx == IDX_LAST);
      pre_n         = tick ? '0 : pre_cnt + 1'b1;
      pwm_n         = tick ? pwm_cnt + 4'd1 : pwm_cnt;
      idx_n         = idx;
      blink_cnt_n   = blink_cnt;
      blink_phase_n = blink_phase;
      val_n         = slot_val;
      dp_bit_n      = slot_dp;
      vis_n         = slot_vis;

      if (slot_end) begin
         idx_n = wrap ? '0 : idx + 1'b1;
      end

      if (wrap) begin
         if (blink_cnt == BLK_LAST) begin
            blink_cnt_n   = '0;
            blink_phase_n = ~blink_phase;
         end else begin
            blink_cnt_n = blink_cnt + 1'b1;
         end
      end

      // The new slot sees the blink phase that is valid for its own frame.
      if (slot_end) begin
         val_n    = digits[4*idx_n +: 4];
         dp_bit_n = dp_in[idx_n];
         vis_n    = ~blank[idx_n]
                  & ~(blink[idx_n] & blink_phase_n)
                  & ~(lz_en & (idx_n != '0) & upper_zero[idx_n]);
      end

      // pwm 15 can never satisfy pwm < bright, giving the anti-ghost gap.
      lit_n = vis_n && (pwm_n < bright);
   end

   seg_decoder u_seg_decoder (
      .value (val_n),
      .ca    (seg_n)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pre_cnt     <= '0;
         pwm_cnt     <= '0;
         idx         <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         // NOTE: the slot registers are plain flops, not a memory, so they
         // are reset; visible = 0 keeps the first slot dark until captured.
         slot_val    <= '0;
         slot_dp     <= 1'b0;
         slot_vis    <= 1'b0;
         an          <= '1;
         ca          <= SEG_OFF;
         dp          <= 1'b1;
         frame_tick  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees the values
         // from before this edge, independent of statement order.
         pre_cnt     <= pre_n;
         pwm_cnt     <= pwm_n;
         idx         <= idx_n;
         blink_cnt   <= blink_cnt_n;
         blink_phase <= blink_phase_n;
         slot_val    <= val_n;
         slot_dp     <= dp_bit_n;
         slot_vis    <= vis_n;
         frame_tick  <= wrap;
         // Pins only move on ticks, so bright is sampled once per tick.
         if (tick) begin
            an <= lit_n ? ~(NUM_DIGITS'(1) << idx_n) : '1;
            ca <= lit_n ? seg_n : SEG_OFF;
            dp <= lit_n ? ~dp_bit_n : 1'b1;
         end
      end
   end

endmodule
